// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router with header tagging.
// Define ROUTER_FIFO_TRISTATE_EN to float data_out while idle.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_W - 1;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             oe_q, oe_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH:0]   rd_ent;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_ok  = write_enb & ~full;
  assign rd_ok  = read_enb & ~empty;
  assign rd_ent = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    oe_d     = oe_q;
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      oe_d     = 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dat_d    = rd_ent[WIDTH-1:0];
        oe_d     = 1'b1;
        // header length counts payload plus the parity byte
        if (rd_ent[WIDTH])
          cnt_d = 7'(rd_ent[7:2]) + 7'd1;
        else if (cnt_q != 7'd0)
          cnt_d = cnt_q - 7'd1;
      end else if (cnt_q == 7'd0) begin
        oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dat_q    <= '0;
      oe_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      oe_q     <= oe_d;
    end
  end

  // storage is intentionally left uncleared by either reset
  always_ff @(posedge clock) begin
    if (wr_ok && !soft_reset)
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  assign data_out = oe_q ? dat_q : {WIDTH{1'bz}};
`else
  assign data_out = oe_q ? dat_q : '0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Default build: idle output value is 8'h00.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_chk = 0;
  int n_bad = 0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic sr);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    @(posedge clock);
    #1;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    soft_reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    step(1'b1, 1'b0, lfd, d, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk(tag, data_out, exp);
  endtask

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 8'h00);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // fill to full, overflow write, drain
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_at15", full, 0);
      wr(8'h10 + 8'(i), 1'b0);
    end
    chk("full_at16", full, 1);
    wr(8'hAA, 1'b0);
    chk("full_after_ovf", full, 1);
    for (int i = 0; i < 16; i++)
      rd("fill_rd", 8'h10 + 8'(i));
    chk("fill_empty", empty, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("fill_idle", data_out, 8'h00);

    // packet drain: header 0D gives 3 payload + parity
    wr(8'h0D, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    wr(8'h03, 1'b0);
    wr(8'h0F, 1'b0);
    rd("pkt_hdr", 8'h0D);
    rd("pkt_p1", 8'h01);
    rd("pkt_p2", 8'h02);
    rd("pkt_p3", 8'h03);
    rd("pkt_par", 8'h0F);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pkt_idle", data_out, 8'h00);
    chk("pkt_empty", empty, 1);

    // concurrent read and write at occupancy 4
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
      chk("cc_rd", data_out, 8'hA0 + 8'(i));
    end
    chk("cc_empty", empty, 0);
    chk("cc_full", full, 0);
    rd("cc_d0", 8'hA3);
    rd("cc_d1", 8'hB0);
    rd("cc_d2", 8'hB1);
    rd("cc_d3", 8'hB2);
    chk("cc_drained", empty, 1);

    // read+write while full: write dropped
    for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i), 1'b0);
    chk("fw_full", full, 1);
    step(1'b1, 1'b1, 1'b0, 8'hD0, 1'b0);
    chk("fw_rd", data_out, 8'hC0);
    chk("fw_notfull", full, 0);
    for (int i = 1; i < 16; i++)
      rd("fw_drain", 8'hC0 + 8'(i));
    chk("fw_empty", empty, 1);

    // soft reset mid-packet with coincident write
    wr(8'h0D, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    wr(8'h03, 1'b0);
    wr(8'h0F, 1'b0);
    rd("sr_hdr", 8'h0D);
    rd("sr_p1", 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
    chk("sr_empty", empty, 1);
    chk("sr_full", full, 0);
    chk("sr_dout", data_out, 8'h00);
    wr(8'h09, 1'b1);
    rd("sr_newhdr", 8'h09);
    chk("sr_after_empty", empty, 1);

    // async reset between edges while full
    for (int i = 0; i < 16; i++) wr(8'hE0 + 8'(i), 1'b0);
    chk("ar_full", full, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_full0", full, 0);
    chk("ar_empty1", empty, 1);
    chk("ar_dout", data_out, 8'h00);
    #1;
    resetn = 1'b1;
    wr(8'h55, 1'b0);
    rd("ar_rd55", 8'h55);

    // 40 write/read pairs to wrap the pointers
    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 7 + 3), 1'b0);
      chk("wrap_nofull", full, 0);
      rd("wrap_rd", 8'(i * 7 + 3));
    end
    chk("wrap_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
